rom_port_arbiter: RTL and testbench

//  Shares the single-read-port instruction ROM between the instruction-fetch port (IF) and the

---
 rtl/rom_port_arbiter_if.sv | 32 +++
 rtl/rom_port_arbiter.sv | 100 ++++++++++
 tb/tb_rom_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// Requester-side bundle for the shared ROM read port.
// It carries the IF and DM request/response handshakes.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 12
) ();
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_flush;
    logic              if_resp_valid;
    logic [31:0]       if_resp_data;

    logic              dm_req_valid;
    logic [ADDR_W-1:0] dm_req_addr;
    logic              dm_req_ready;
    logic              dm_resp_valid;
    logic [31:0]       dm_resp_data;

    // Core fetch/load units.
    modport master (
        output if_req_valid, if_req_addr, if_flush, dm_req_valid, dm_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  dm_req_ready, dm_resp_valid, dm_resp_data
    );

    // Arbiter.
    modport slave (
        input  if_req_valid, if_req_addr, if_flush, dm_req_valid, dm_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        output dm_req_ready, dm_resp_valid, dm_resp_data
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM read port between instruction fetch (IF) and data loads (DM).
// It issues one grant per cycle and returns the ROM word one cycle after the grant.
module rom_port_arbiter #(
    parameter int ROM_ADDRESS_BITWIDTH = 12,
    parameter int MAX_DM_STREAK        = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    rom_port_arbiter_if.slave               bus,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    input  logic [31:0]                     rom_data
);
    localparam int                          W          = ROM_ADDRESS_BITWIDTH;
    localparam logic [3:0]                  STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [W-1:0]                ALIGN_MASK = ~W'(3);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    owner_t       owner, owner_next;
    logic [3:0]   dm_streak, dm_streak_next;
    logic [W-1:0] addr_q, addr_next;
    logic         if_eligible, dm_eligible;
    logic         grant_if, grant_dm;

    // A flushed fetch cannot win the port in the cycle it is flushed.
    // DM still competes in that cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        if_eligible = bus.if_req_valid && !bus.if_flush && !reset;
        dm_eligible = bus.dm_req_valid && !reset;
        if (if_eligible && dm_eligible) begin
            if (dm_streak == STREAK_MAX) grant_if = 1'b1;
            else                         grant_dm = 1'b1;
        end else if (if_eligible) begin
            grant_if = 1'b1;
        end else if (dm_eligible) begin
            grant_dm = 1'b1;
        end
    end

    // The streak only counts DM wins taken while IF was waiting.
    // A flush cycle freezes it so that a redirect does not use up IF's turn.
    always_comb begin
        dm_streak_next = dm_streak;
        if (!bus.if_req_valid) begin
            dm_streak_next = 4'd0;
        end else if (!bus.if_flush) begin
            if (grant_if) begin
                dm_streak_next = 4'd0;
            end else if (grant_dm && dm_streak != STREAK_MAX) begin
                dm_streak_next = dm_streak + 4'd1;
            end
        end
    end

    always_comb begin
        addr_next = addr_q;
        if (grant_if)      addr_next = bus.if_req_addr & ALIGN_MASK;
        else if (grant_dm) addr_next = bus.dm_req_addr & ALIGN_MASK;
    end

    // Owner FSM: this cycle's grant becomes next cycle's response owner.
    always_comb begin
        owner_next        = OWN_NONE;
        bus.if_resp_valid = 1'b0;
        bus.dm_resp_valid = 1'b0;
        if (grant_if)      owner_next = OWN_IF;
        else if (grant_dm) owner_next = OWN_DM;
        case (owner)
            OWN_IF:  bus.if_resp_valid = !bus.if_flush && !reset;
            OWN_DM:  bus.dm_resp_valid = !reset;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            owner     <= OWN_NONE;
            dm_streak <= 4'd0;
            addr_q    <= '0;
        end else begin
            owner     <= owner_next;
            dm_streak <= dm_streak_next;
            addr_q    <= addr_next;
        end
    end

    assign bus.if_req_ready = grant_if;
    assign bus.dm_req_ready = grant_dm;
    assign bus.if_resp_data = rom_data;
    assign bus.dm_resp_data = rom_data;
    assign rom_address      = reset ? '0 : addr_next;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a registered ROM model.
// Expected responses are queued at issue time and checked by an independent monitor.
module tb_rom_port_arbiter;
    localparam int W = 12;

    logic          clk;
    logic          reset;
    logic [W-1:0]  rom_address;
    logic [31:0]   rom_data;

    rom_port_arbiter_if #(.ADDR_W(W)) bus ();

    rom_port_arbiter #(
        .ROM_ADDRESS_BITWIDTH(W),
        .MAX_DM_STREAK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .rom_address(rom_address),
        .rom_data(rom_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: word i holds 0xB000_0000 | i.
    always @(posedge clk) rom_data <= 32'hB000_0000 | 32'(rom_address[W-1:2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_dm;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: each cycle it pops whatever response is due and checks both ports.
    always @(negedge clk) begin
        logic        exp_if;
        logic        exp_dm;
        logic [31:0] exp_d;
        exp_if = 1'b0;
        exp_dm = 1'b0;
        exp_d  = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_if = !sb[0].is_dm;
            exp_dm = sb[0].is_dm;
            exp_d  = sb[0].data;
            void'(sb.pop_front());
        end
        check("if_resp_valid", 32'(bus.if_resp_valid), 32'(exp_if));
        check("dm_resp_valid", 32'(bus.dm_resp_valid), 32'(exp_dm));
        if (exp_if) check("if_resp_data", bus.if_resp_data, exp_d);
        if (exp_dm) check("dm_resp_data", bus.dm_resp_data, exp_d);
    end

    // One cycle of stimulus: drive inputs, check grants and the ROM address,
    // and queue the response that must follow.
    task automatic step(input string name, input logic rst,
                        input logic ifv, input logic [W-1:0] ifa, input logic fl,
                        input logic dmv, input logic [W-1:0] dma,
                        input logic exp_ifr, input logic exp_dmr,
                        input logic [W-1:0] exp_addr, input logic resp_ok);
        exp_t e;
        reset            = rst;
        bus.if_req_valid = ifv;
        bus.if_req_addr  = ifa;
        bus.if_flush     = fl;
        bus.dm_req_valid = dmv;
        bus.dm_req_addr  = dma;
        @(negedge clk);
        check({name, ".if_req_ready"}, 32'(bus.if_req_ready), 32'(exp_ifr));
        check({name, ".dm_req_ready"}, 32'(bus.dm_req_ready), 32'(exp_dmr));
        check({name, ".rom_address"},  32'(rom_address),      32'(exp_addr));
        if (resp_ok && (exp_ifr || exp_dmr)) begin
            e.is_dm = exp_dmr;
            e.cyc   = cyc + 1;
            e.data  = 32'hB000_0000 | 32'(exp_addr[W-1:2]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
        bus.if_flush     = 1'b0;
        bus.dm_req_valid = 1'b0;
        bus.dm_req_addr  = '0;

        // Reset with both requesters active: no grants, address 0.
        step("rst0", 1, 1, 12'h100, 0, 1, 12'h200, 0, 0, 12'h000, 0);
        step("rst1", 1, 1, 12'h100, 0, 1, 12'h200, 0, 0, 12'h000, 0);

        // IF alone, then an idle cycle holds the address.
        step("if_only", 0, 1, 12'h010, 0, 0, 12'h000, 1, 0, 12'h010, 1);
        step("idle0",   0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h010, 0);

        // Contention: DM first, IF next cycle.
        step("both_dm", 0, 1, 12'h000, 0, 1, 12'h020, 0, 1, 12'h020, 1);
        step("if_next", 0, 1, 12'h000, 0, 0, 12'h000, 1, 0, 12'h000, 1);

        // Streak limit of 4: DM x4, then IF (misaligned 0x7FF -> 0x7FC), then DM again.
        step("stk1", 0, 1, 12'h7FF, 0, 1, 12'h040, 0, 1, 12'h040, 1);
        step("stk2", 0, 1, 12'h7FF, 0, 1, 12'h044, 0, 1, 12'h044, 1);
        step("stk3", 0, 1, 12'h7FF, 0, 1, 12'h048, 0, 1, 12'h048, 1);
        step("stk4", 0, 1, 12'h7FF, 0, 1, 12'h04C, 0, 1, 12'h04C, 1);
        step("stk_if", 0, 1, 12'h7FF, 0, 1, 12'h050, 1, 0, 12'h7FC, 1);
        step("stk_dm", 0, 1, 12'h100, 0, 1, 12'h050, 0, 1, 12'h050, 1);
        step("stk_mis", 0, 1, 12'h100, 0, 1, 12'h055, 0, 1, 12'h054, 1);
        step("stk_ifb", 0, 1, 12'h100, 0, 0, 12'h000, 1, 0, 12'h100, 1);
        step("idle1",   0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h100, 0);

        // Flush squashes the pending IF response and blocks the IF grant.
        // DM wins that cycle without advancing the streak.
        step("fl_if",  0, 1, 12'h008, 0, 0, 12'h000, 1, 0, 12'h008, 0);
        step("fl_dm",  0, 1, 12'h00C, 1, 1, 12'h030, 0, 1, 12'h030, 1);
        step("fl_s1",  0, 1, 12'h00C, 0, 1, 12'h034, 0, 1, 12'h034, 1);
        step("fl_s2",  0, 1, 12'h00C, 0, 1, 12'h038, 0, 1, 12'h038, 1);
        step("fl_s3",  0, 1, 12'h00C, 0, 1, 12'h03C, 0, 1, 12'h03C, 1);
        step("fl_hold", 0, 1, 12'h00C, 1, 1, 12'h040, 0, 1, 12'h040, 1);
        step("fl_s4",  0, 1, 12'h00C, 0, 1, 12'h044, 0, 1, 12'h044, 1);
        step("fl_ifw", 0, 1, 12'h00C, 0, 1, 12'h048, 1, 0, 12'h00C, 1);
        step("idle2",  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h00C, 0);

        // Reset right after a DM grant drops its response; traffic resumes afterwards.
        step("mr_dm",  0, 0, 12'h000, 0, 1, 12'h060, 0, 1, 12'h060, 0);
        step("mr_rst", 1, 1, 12'h100, 0, 1, 12'h200, 0, 0, 12'h000, 0);
        step("mr_if",  0, 1, 12'h018, 0, 0, 12'h000, 1, 0, 12'h018, 1);
        step("idle3",  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h018, 0);
        step("idle4",  0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h018, 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
